// File: rtl/sram_pkg.sv
// Shared types and helpers for the synchronous single-port SRAM.
package sram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int unsigned nbytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Even parity: the stored bit makes the byte plus parity have an even number of ones.
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Storage array with per-byte write enables and a synchronous read register.
// Optional per-byte parity column when SRAM_PARITY_EN is defined.
module sram_array
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RAM_DEPTH  = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic                           re,
  input  logic                           rd_clr,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [nbytes(DATA_WIDTH)-1:0]  be,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           par_err
);

  localparam int unsigned NB = nbytes(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Out-of-range reads load zero so the response carries no stale data.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_clr)  rdata_d = '0;
    else if (re) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

`ifdef SRAM_PARITY_EN
  logic [NB-1:0] par_q [RAM_DEPTH];
  logic [NB-1:0] par_calc_c;
  logic          par_err_q, par_err_d;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) par_q[addr][i] <= even_par(wdata[8*i +: 8]);
      end
    end
  end

  always_comb begin
    par_calc_c = '0;
    for (int i = 0; i < NB; i++) par_calc_c[i] = even_par(mem_q[addr][8*i +: 8]);
  end

  always_comb begin
    par_err_d = par_err_q;
    if (rd_clr)  par_err_d = 1'b0;
    else if (re) par_err_d = (par_calc_c != par_q[addr]);
  end

  always_ff @(posedge clk) begin
    if (reset) par_err_q <= 1'b0;
    else       par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: rtl/sram_sp_sync.sv
// Synchronous single-port SRAM: valid/ready requests, 1-cycle read response,
// self-clearing init after reset. Define SRAM_PARITY_EN for per-byte parity.
module sram_sp_sync
  import sram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           RAM_DEPTH  = 256,
  parameter int unsigned           INIT_ADDR  = 124,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = 16'h3779
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  input  logic [nbytes(DATA_WIDTH)-1:0]  req_be,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           init_busy,
  output logic                           addr_err,
  output logic                           rsp_par_err
);

  localparam int unsigned NB  = nbytes(DATA_WIDTH);
  localparam int unsigned AW1 = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  init_busy_q, init_busy_d;
  logic                  addr_err_q, addr_err_d;

  logic                  accept_c, oor_c;
  logic                  arr_we, arr_re, arr_clr;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [NB-1:0]         arr_be;

  // A stalled response blocks new requests so it is never overwritten.
  assign req_ready = (state_q == ST_RUN) && !(rsp_valid_q && !rsp_ready);
  assign accept_c  = req_valid && req_ready;
  assign oor_c     = {1'b0, req_addr} >= AW1'(RAM_DEPTH);

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rsp_valid_d = rsp_valid_q;
    addr_err_d  = 1'b0;
    arr_we      = 1'b0;
    arr_re      = 1'b0;
    arr_clr     = 1'b0;
    arr_addr    = req_addr;
    arr_wdata   = req_wdata;
    arr_be      = req_be;

    case (state_q)
      ST_INIT: begin
        arr_we    = 1'b1;
        arr_addr  = init_cnt_q;
        arr_be    = '1;
        arr_wdata = (init_cnt_q == ADDR_WIDTH'(INIT_ADDR)) ? INIT_VALUE : '0;
        if (init_cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1)) state_d = ST_RUN;
        else                                          init_cnt_d = init_cnt_q + 1'b1;
      end
      ST_RUN: begin
        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
        if (accept_c) begin
          addr_err_d = oor_c;
          if (req_write) begin
            arr_we = !oor_c;
          end else begin
            rsp_valid_d = 1'b1;
            arr_re      = !oor_c;
            arr_clr     = oor_c;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase

    init_busy_d = (state_d == ST_INIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      init_busy_q <= 1'b1;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      init_busy_q <= init_busy_d;
      addr_err_q  <= addr_err_d;
    end
  end

  sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we      (arr_we),
    .re      (arr_re),
    .rd_clr  (arr_clr),
    .addr    (arr_addr),
    .wdata   (arr_wdata),
    .be      (arr_be),
    .rdata   (rsp_rdata),
    .par_err (rsp_par_err)
  );

  assign rsp_valid = rsp_valid_q;
  assign init_busy = init_busy_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_sram_sp_sync.sv
// Directed, scoreboard-checked bench for sram_sp_sync (default depth and a 200-word instance).
module tb_sram_sp_sync;

  logic        clk;
  logic        reset;
  logic        req_valid, req_valid2;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_ready;

  logic        req_ready, rsp_valid, init_busy, addr_err, rsp_par_err;
  logic [15:0] rsp_rdata;
  logic        req_ready2, rsp_valid2, init_busy2, addr_err2, rsp_par_err2;
  logic [15:0] rsp_rdata2;

  int checks   = 0;
  int failures = 0;
  int flip_addr = -1;

  logic [15:0] model1 [256];
  logic [15:0] model2 [200];
  logic [16:0] q1 [$];
  logic [16:0] q2 [$];

  sram_sp_sync u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_busy(init_busy), .addr_err(addr_err), .rsp_par_err(rsp_par_err)
  );

  sram_sp_sync #(.RAM_DEPTH(200)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata2),
    .init_busy(init_busy2), .addr_err(addr_err2), .rsp_par_err(rsp_par_err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model1[i] = 16'h0000;
    for (int i = 0; i < 200; i++) model2[i] = 16'h0000;
    model1[124] = 16'h3779;
    model2[124] = 16'h3779;
  endtask

  // Score responses about to handshake, record accepted requests, then advance one clock.
  task automatic tick();
    logic [16:0] e;
    logic        pe;
    if (rsp_valid && rsp_ready) begin
      chk("rsp1_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("rsp1_rdata", 32'(rsp_rdata), 32'(e[15:0]));
        chk("rsp1_par_err", 32'(rsp_par_err), 32'(e[16]));
      end
    end
    if (rsp_valid2 && rsp_ready) begin
      chk("rsp2_expected", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        chk("rsp2_rdata", 32'(rsp_rdata2), 32'(e[15:0]));
        chk("rsp2_par_err", 32'(rsp_par_err2), 32'(e[16]));
      end
    end
    if (req_valid && req_ready) begin
      if (req_write) begin
        for (int i = 0; i < 2; i++)
          if (req_be[i]) model1[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
      end else begin
        pe = (int'(req_addr) == flip_addr);
        q1.push_back({pe, model1[req_addr]});
      end
    end
    if (req_valid2 && req_ready2) begin
      if (req_write) begin
        if (req_addr < 8'd200)
          for (int i = 0; i < 2; i++)
            if (req_be[i]) model2[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
      end else begin
        q2.push_back((req_addr < 8'd200) ? {1'b0, model2[req_addr]} : 17'h0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit dut2, input logic wr, input logic [7:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    int n = 0;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    if (dut2) req_valid2 = 1'b1; else req_valid = 1'b1;
    while (!(dut2 ? req_ready2 : req_ready) && n < 50) begin
      tick();
      n++;
    end
    chk(dut2 ? "req_accept2" : "req_accept1", 32'(dut2 ? req_ready2 : req_ready), 32'd1);
    tick();
    req_valid  = 1'b0;
    req_valid2 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rsp_ready = 1'b1;
    while ((q1.size() != 0 || q2.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_q1", 32'(q1.size()), 32'd0);
    chk("drain_q2", 32'(q2.size()), 32'd0);
  endtask

  task automatic wait_init(output int cyc, output int busy);
    cyc  = 0;
    busy = 0;
    while (!req_ready && cyc < 400) begin
      if (init_busy) busy++;
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc, busy;
    reset = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    repeat (3) tick();

    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_par_err", 32'(rsp_par_err), 32'd0);

    reset = 1'b0;
    wait_init(cyc, busy);
    chk("init_cycles", 32'(cyc), 32'd256);
    chk("init_busy_cycles", 32'(busy), 32'd256);
    chk("init_busy_low", 32'(init_busy), 32'd0);
    chk("init2_done", 32'(init_busy2), 32'd0);

    // Post-init contents, back-to-back reads
    issue(0, 1'b0, 8'd0, '0, '0);
    issue(0, 1'b0, 8'd124, '0, '0);
    issue(0, 1'b0, 8'd255, '0, '0);
    drain();

    // Write followed immediately by read of the same word
    issue(0, 1'b1, 8'h12, 16'hA5C3, 2'b11);
    issue(0, 1'b0, 8'h12, '0, '0);
    chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2_rdata", 32'(rsp_rdata), 32'hA5C3);
    drain();

    // Partial and empty byte enables
    issue(0, 1'b1, 8'h12, 16'hFFFF, 2'b01);
    issue(0, 1'b0, 8'h12, '0, '0);
    chk("t3_be01", 32'(rsp_rdata), 32'hA5FF);
    issue(0, 1'b1, 8'h12, 16'h0000, 2'b00);
    issue(0, 1'b0, 8'h12, '0, '0);
    chk("t3_be00", 32'(rsp_rdata), 32'hA5FF);
    drain();

    // Response backpressure
    issue(0, 1'b1, 8'd5, 16'h1234, 2'b11);
    rsp_ready = 1'b0;
    issue(0, 1'b0, 8'd5, '0, '0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_req_ready_low", 32'(req_ready), 32'd0);
      chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t4_rdata_stable", 32'(rsp_rdata), 32'h1234);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("t4_rsp_valid_clr", 32'(rsp_valid), 32'd0);
    chk("t4_req_ready_back", 32'(req_ready), 32'd1);
    chk("t4_q_empty", 32'(q1.size()), 32'd0);

    // Out-of-range on the 200-word instance
    issue(1, 1'b1, 8'hF0, 16'hBEEF, 2'b11);
    chk("t5_addr_err_wr", 32'(addr_err2), 32'd1);
    issue(1, 1'b0, 8'hF0, '0, '0);
    chk("t5_addr_err_rd", 32'(addr_err2), 32'd1);
    chk("t5_rsp_valid", 32'(rsp_valid2), 32'd1);
    chk("t5_rdata_zero", 32'(rsp_rdata2), 32'd0);
    tick();
    chk("t5_addr_err_pulse", 32'(addr_err2), 32'd0);
    chk("t5_addr_err_dut1", 32'(addr_err), 32'd0);
    for (int a = 0; a < 200; a++) issue(1, 1'b0, 8'(a), '0, '0);
    chk("t5_addr_err_inrange", 32'(addr_err2), 32'd0);
    drain();

    // Reset during a stalled response
    rsp_ready = 1'b0;
    issue(0, 1'b0, 8'h12, '0, '0);
    tick();
    reset = 1'b1;
    tick();
    q1.delete();
    q2.delete();
    model_reset();
    chk("t6_rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("t6_rdata_clr", 32'(rsp_rdata), 32'd0);
    chk("t6_init_busy", 32'(init_busy), 32'd1);
    chk("t6_req_ready", 32'(req_ready), 32'd0);

    // Reset during INIT
    reset = 1'b0;
    rsp_ready = 1'b1;
    repeat (50) tick();
    chk("t6_mid_init_busy", 32'(init_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_init(cyc, busy);
    chk("t6_init_cycles", 32'(cyc), 32'd256);
    for (int a = 0; a < 256; a++) issue(0, 1'b0, 8'(a), '0, '0);
    drain();

`ifdef SRAM_PARITY_EN
    u_dut.u_array.mem_q[7] = 16'h0001;
    model1[7] = 16'h0001;
    flip_addr = 7;
    issue(0, 1'b0, 8'd7, '0, '0);
    chk("t6_par_err", 32'(rsp_par_err), 32'd1);
    chk("t6_par_data", 32'(rsp_rdata), 32'h0001);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
